vga_pixel_path: RTL and testbench

Downstream stage of the VGA sync/timing generator. Consumes raw H_SYNC, V_SYNC and active-video enable from the timing block, fetches packed RGB332 pixels from the framebuffer memory port, and drives the DAC colour lines. Re-times the syncs so they stay pixel-aligned with the colour data.

---
 rtl/vga_pixel_path.sv | 139 +++++++++++++
 tb/tb_vga_pixel_path.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_path.sv
// vga_pixel_path: fetches packed RGB332 pixels and re-times VGA syncs to match.
// Optional 8-bar test pattern input: define VGA_PIXEL_PATH_TESTPAT_EN.
module vga_pixel_path #(
    parameter int   MEM_LAT     = 2,
    parameter int   ADDR_W      = 16,
    parameter int   FB_WORDS    = 38400,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              H_SYNC_IN,
    input  logic              V_SYNC_IN,
    input  logic              DE_IN,
`ifdef VGA_PIXEL_PATH_TESTPAT_EN
    input  logic              TESTPAT,
`endif
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_RD,
    input  logic [15:0]       MEM_DATA,
    output logic [2:0]        RED,
    output logic [2:0]        GRN,
    output logic [1:0]        BLU,
    output logic              H_SYNC,
    output logic              V_SYNC,
    output logic              DE_OUT
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_WORDS - 1);

    logic              parity;
    logic [ADDR_W-1:0] addr_ctr;
    logic [MEM_LAT:0]  de_d;
    logic [MEM_LAT:0]  hs_d;
    logic [MEM_LAT:0]  vs_d;
    logic [MEM_LAT:0]  par_d;
    logic [7:0]        hold_hi;
    logic [7:0]        pix;
    logic              vs_act;
    logic              issue;
    logic              de_l;
    logic              par_l;

    assign vs_act = (V_SYNC_IN == SYNC_ACTIVE);
    assign issue  = DE_IN && !parity;
    assign de_l   = de_d[MEM_LAT];
    assign par_l  = par_d[MEM_LAT];

    // Pixel parity, frame address counter and one read per even pixel.
    // A read during vsync (malformed timing) goes to the cleared address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity   <= 1'b0;
            addr_ctr <= '0;
            MEM_RD   <= 1'b0;
            MEM_ADDR <= '0;
        end else begin
            parity <= DE_IN ? ~parity : 1'b0;
            MEM_RD <= issue;
            if (issue) begin
                MEM_ADDR <= vs_act ? '0 : addr_ctr;
            end
            if (vs_act) begin
                addr_ctr <= '0;
            end else if (issue) begin
                addr_ctr <= (addr_ctr == LAST) ? '0 : addr_ctr + ADDR_W'(1);
            end
        end
    end

    // Sideband delay line; the output registers form its final stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_d  <= '0;
            par_d <= '0;
            hs_d  <= {(MEM_LAT + 1){~SYNC_ACTIVE}};
            vs_d  <= {(MEM_LAT + 1){~SYNC_ACTIVE}};
        end else begin
            de_d  <= {de_d[MEM_LAT-1:0], DE_IN};
            par_d <= {par_d[MEM_LAT-1:0], parity};
            hs_d  <= {hs_d[MEM_LAT-1:0], H_SYNC_IN};
            vs_d  <= {vs_d[MEM_LAT-1:0], V_SYNC_IN};
        end
    end

    // Keep the odd pixel of the word arriving alongside an even pixel.
    always_ff @(posedge clk) begin
        if (de_l && !par_l) begin
            hold_hi <= MEM_DATA[15:8];
        end
    end

`ifdef VGA_PIXEL_PATH_TESTPAT_EN
    logic [6:0] pix_idx;
    logic [2:0] bar;

    assign bar = pix_idx[6:4];

    // Pixel index within the current output line, for the bar pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_idx <= '0;
        end else if (de_l) begin
            pix_idx <= pix_idx + 7'd1;
        end else begin
            pix_idx <= '0;
        end
    end
`endif

    // Even pixel comes straight off the bus, odd pixel from the held word.
    always_comb begin
        pix = par_l ? hold_hi : MEM_DATA[7:0];
`ifdef VGA_PIXEL_PATH_TESTPAT_EN
        if (TESTPAT) begin
            pix = {bar[1:0], bar, bar};
        end
`endif
    end

    // Output stage: colour with blanking, plus the re-timed syncs.
    always_ff @(posedge clk) begin
        if (rst) begin
            RED    <= '0;
            GRN    <= '0;
            BLU    <= '0;
            DE_OUT <= 1'b0;
            H_SYNC <= ~SYNC_ACTIVE;
            V_SYNC <= ~SYNC_ACTIVE;
        end else begin
            RED    <= de_l ? pix[7:5] : '0;
            GRN    <= de_l ? pix[4:2] : '0;
            BLU    <= de_l ? pix[1:0] : '0;
            DE_OUT <= de_l;
            H_SYNC <= hs_d[MEM_LAT];
            V_SYNC <= vs_d[MEM_LAT];
        end
    end

endmodule

// File: tb/tb_vga_pixel_path.sv
// tb_vga_pixel_path: randomized bench with a pixel-level reference model.
// Uses MEM_LAT=2, FB_WORDS=5, active-low syncs.
module tb_vga_pixel_path;

    localparam int LAT = 2;
    localparam int FBW = 5;
    localparam int N   = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic        de_in = 1'b0;
`ifdef VGA_PIXEL_PATH_TESTPAT_EN
    logic        testpat = 1'b0;
`endif
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data = 16'h0;
    logic [2:0]  red;
    logic [2:0]  grn;
    logic [1:0]  blu;
    logic        hs;
    logic        vs;
    logic        de_out;

    logic [15:0] mem [FBW];
    logic        prd = 1'b0;
    int          padr = 0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        l_rd [N];
    logic [15:0] l_adr [N];
    logic [7:0]  l_byte [N];
    logic        l_hs [N];
    logic        l_vs [N];
    logic        l_de [N];
    logic        i_rst [N];
    logic        i_hs [N];
    logic        i_vs [N];
    logic        i_de [N];
    logic        e_rd [N];
    int          e_adr [N];
    logic [7:0]  e_byte [N];

    int m_par = 0;
    int m_addr = 0;
    int m_last = 0;

    vga_pixel_path #(
        .MEM_LAT(LAT),
        .ADDR_W(16),
        .FB_WORDS(FBW),
        .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .H_SYNC_IN(hs_in),
        .V_SYNC_IN(vs_in),
        .DE_IN(de_in),
`ifdef VGA_PIXEL_PATH_TESTPAT_EN
        .TESTPAT(testpat),
`endif
        .MEM_ADDR(mem_addr),
        .MEM_RD(mem_rd),
        .MEM_DATA(mem_data),
        .RED(red),
        .GRN(grn),
        .BLU(blu),
        .H_SYNC(hs),
        .V_SYNC(vs),
        .DE_OUT(de_out)
    );

    always #5 clk = ~clk;

    // Framebuffer: data valid LAT cycles after the strobe is seen, junk otherwise.
    always @(posedge clk) begin
        mem_data <= prd ? ((padr < FBW) ? mem[padr] : 16'hDEAD) : 16'($urandom);
        prd      <= mem_rd;
        padr     <= int'(mem_addr);
    end

    // One cycle: log outputs, apply inputs, advance the pixel-level model.
    task automatic tick(input logic r, input logic d, input logic h, input logic v);
        @(negedge clk);
        l_rd[cyc]   = mem_rd;
        l_adr[cyc]  = mem_addr;
        l_byte[cyc] = {red, grn, blu};
        l_hs[cyc]   = hs;
        l_vs[cyc]   = vs;
        l_de[cyc]   = de_out;
        rst = r;
        de_in = d;
        hs_in = h;
        vs_in = v;
        i_rst[cyc] = r;
        i_de[cyc]  = d;
        i_hs[cyc]  = h;
        i_vs[cyc]  = v;
        e_rd[cyc]   = 1'b0;
        e_adr[cyc]  = 0;
        e_byte[cyc] = 8'h00;
        if (r) begin
            m_par  = 0;
            m_addr = 0;
        end else begin
            if (d) begin
                if (m_par == 0) begin
                    m_last      = (v == 1'b0) ? 0 : m_addr;
                    e_rd[cyc]   = 1'b1;
                    e_adr[cyc]  = m_last;
                    e_byte[cyc] = mem[m_last][7:0];
                    m_addr      = (m_addr + 1) % FBW;
                end else begin
                    e_byte[cyc] = mem[m_last][15:8];
                end
                m_par = 1 - m_par;
            end else begin
                m_par = 0;
            end
            if (v == 1'b0) m_addr = 0;
        end
        cyc++;
    endtask

    function automatic bit flushed(int n);
        if (n < 4) return 1'b1;
        for (int k = n - 4; k < n; k++) begin
            if (i_rst[k]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic vpulse();
        idle(2);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
    endtask

    task automatic test_reset();
        int s;
        s = cyc;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 1'(i & 1), 1'(~i & 1));
        end
        idle(4);
        for (int n = s + 1; n <= s + 6; n++) begin
            checks++;
            if ({l_byte[n], l_de[n], l_rd[n], l_hs[n], l_vs[n]} !== {8'h00, 4'b0011}) begin
                errors++;
                $display("FAIL reset cyc %0d: rgb=%h de=%b rd=%b hs=%b vs=%b, want 00 0 0 1 1",
                         n, l_byte[n], l_de[n], l_rd[n], l_hs[n], l_vs[n]);
            end
            checks++;
            if (l_adr[n] !== 16'h0) begin
                errors++;
                $display("FAIL reset_addr cyc %0d: got %h want 0000", n, l_adr[n]);
            end
        end
    endtask

    task automatic test_basic_fetch();
        int t;
        logic [7:0] eb [4];
        eb = '{8'h1C, 8'hE0, 8'hFF, 8'h03};
        mem[0] = 16'hE01C;
        mem[1] = 16'h03FF;
        vpulse();
        t = cyc;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 1'b1);
        idle(8);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (l_rd[t+1+i] !== 1'((i % 2) == 0)) begin
                errors++;
                $display("FAIL basic_rd cyc %0d: got %b want %b", t + 1 + i, l_rd[t+1+i], (i % 2) == 0);
            end
            if ((i % 2) == 0) begin
                checks++;
                if (l_adr[t+1+i] !== 16'(i / 2)) begin
                    errors++;
                    $display("FAIL basic_addr cyc %0d: got %h want %0d", t + 1 + i, l_adr[t+1+i], i / 2);
                end
            end
            checks++;
            if ({l_de[t+4+i], l_byte[t+4+i]} !== {1'b1, eb[i]}) begin
                errors++;
                $display("FAIL basic_pix %0d: de=%b rgb=%h want de=1 rgb=%h", i, l_de[t+4+i], l_byte[t+4+i], eb[i]);
            end
        end
        checks++;
        if ({l_de[t+3], l_de[t+8], l_byte[t+8]} !== {2'b00, 8'h00}) begin
            errors++;
            $display("FAIL basic_edges: de_before=%b de_after=%b rgb_after=%h want 0 0 00",
                     l_de[t+3], l_de[t+8], l_byte[t+8]);
        end
    endtask

    task automatic test_sync_align();
        int s;
        int p;
        int q;
        int lows;
        idle($urandom_range(0, 15));
        p = $urandom_range(0, 60);
        q = $urandom_range(0, 150);
        s = cyc;
        for (int k = 0; k < 200; k++) begin
            tick(1'b0, 1'($urandom_range(0, 2) != 0),
                 !(k >= p && k < p + 96), !(k >= q && k < q + 5));
        end
        idle(6);
        lows = 0;
        for (int n = s + 4; n < cyc; n++) begin
            if (l_hs[n] === 1'b0) lows++;
            checks++;
            if ({l_hs[n], l_vs[n], l_de[n]} !== {i_hs[n-4], i_vs[n-4], i_de[n-4]}) begin
                errors++;
                $display("FAIL sync_align cyc %0d: hs/vs/de=%b%b%b want %b%b%b",
                         n, l_hs[n], l_vs[n], l_de[n], i_hs[n-4], i_vs[n-4], i_de[n-4]);
            end
        end
        checks++;
        if (lows != 96) begin
            errors++;
            $display("FAIL hsync_width: got %0d want 96", lows);
        end
    endtask

    task automatic test_addr_wrap();
        int s;
        int nrd;
        vpulse();
        s = cyc;
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b1, 1'b1);
        idle(6);
        nrd = 0;
        for (int n = s; n < cyc; n++) begin
            if (l_rd[n] === 1'b1) begin
                checks++;
                if (l_adr[n] !== 16'(nrd % FBW)) begin
                    errors++;
                    $display("FAIL wrap_addr read %0d: got %0d want %0d", nrd, l_adr[n], nrd % FBW);
                end
                nrd++;
            end
        end
        checks++;
        if (nrd != 10) begin
            errors++;
            $display("FAIL wrap_count: got %0d want 10", nrd);
        end
    endtask

    task automatic test_odd_line();
        int s;
        int na;
        int nb;
        int ea [3];
        logic [7:0] eb [5];
        for (int i = 0; i < FBW; i++) mem[i] = 16'($urandom);
        ea = '{0, 1, 2};
        eb = '{mem[0][7:0], mem[0][15:8], mem[1][7:0], mem[2][7:0], mem[2][15:8]};
        vpulse();
        s = cyc;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, 1'b1, 1'b1);
        idle(8);
        na = 0;
        nb = 0;
        for (int n = s; n < cyc; n++) begin
            if (l_rd[n] === 1'b1) begin
                checks++;
                if (na > 2 || l_adr[n] !== 16'(ea[na > 2 ? 2 : na])) begin
                    errors++;
                    $display("FAIL odd_addr read %0d: got %0d", na, l_adr[n]);
                end
                na++;
            end
            if (l_de[n] === 1'b1) begin
                checks++;
                if (nb > 4 || l_byte[n] !== eb[nb > 4 ? 4 : nb]) begin
                    errors++;
                    $display("FAIL odd_pix %0d: got %h want %h", nb, l_byte[n], eb[nb > 4 ? 4 : nb]);
                end
                nb++;
            end
        end
        checks++;
        if (na != 3 || nb != 5) begin
            errors++;
            $display("FAIL odd_counts: reads %0d pixels %0d want 3 5", na, nb);
        end
    endtask

    task automatic test_random();
        int s;
        logic d;
        logic h;
        logic v;
        logic r;
        for (int i = 0; i < FBW; i++) mem[i] = 16'($urandom);
        idle(6);
        s = cyc;
        d = 1'b0;
        h = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) d = ~d;
            if ($urandom_range(0, 9) == 0) h = ~h;
            v = ($urandom_range(0, 24) != 0);
            r = ($urandom_range(0, 199) == 0);
            tick(r, d, h, v);
        end
        idle(6);
        for (int n = s; n < cyc; n++) begin
            checks++;
            if (l_rd[n] !== e_rd[n-1]) begin
                errors++;
                $display("FAIL rand_rd cyc %0d: got %b want %b", n, l_rd[n], e_rd[n-1]);
            end
            if (e_rd[n-1]) begin
                checks++;
                if (l_adr[n] !== 16'(e_adr[n-1])) begin
                    errors++;
                    $display("FAIL rand_addr cyc %0d: got %0d want %0d", n, l_adr[n], e_adr[n-1]);
                end
            end
            checks++;
            if (flushed(n)) begin
                if ({l_de[n], l_hs[n], l_vs[n], l_byte[n]} !== {3'b011, 8'h00}) begin
                    errors++;
                    $display("FAIL rand_flush cyc %0d: de/hs/vs=%b%b%b rgb=%h want 011 00",
                             n, l_de[n], l_hs[n], l_vs[n], l_byte[n]);
                end
            end else if ({l_de[n], l_hs[n], l_vs[n], l_byte[n]}
                         !== {i_de[n-4], i_hs[n-4], i_vs[n-4], e_byte[n-4]}) begin
                errors++;
                $display("FAIL rand_out cyc %0d: de/hs/vs=%b%b%b rgb=%h want %b%b%b %h",
                         n, l_de[n], l_hs[n], l_vs[n], l_byte[n],
                         i_de[n-4], i_hs[n-4], i_vs[n-4], e_byte[n-4]);
            end
        end
    endtask

`ifdef VGA_PIXEL_PATH_TESTPAT_EN
    task automatic test_testpat();
        int s;
        vpulse();
        testpat = 1'b1;
        s = cyc;
        for (int i = 0; i < 32; i++) tick(1'b0, 1'b1, 1'b1, 1'b1);
        idle(6);
        testpat = 1'b0;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if ({l_de[s+4+i], l_byte[s+4+i]} !== {1'b1, (i < 16) ? 8'h00 : 8'h49}) begin
                errors++;
                $display("FAIL testpat pixel %0d: de=%b rgb=%h want 1 %h",
                         i, l_de[s+4+i], l_byte[s+4+i], (i < 16) ? 8'h00 : 8'h49);
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < FBW; i++) mem[i] = 16'($urandom);
        test_reset();
        test_basic_fetch();
        test_sync_align();
        test_addr_wrap();
        test_odd_line();
`ifdef VGA_PIXEL_PATH_TESTPAT_EN
        test_testpat();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
